// File: rtl/rocket_pkg.sv
// Shared encodings for the Rocket tile core enable sequencer: commands, responses, FSM states.

package rocket_pkg;

  typedef enum logic [1:0] {
    CmdNop     = 2'd0,
    CmdStart   = 2'd1,
    CmdStop    = 2'd2,
    CmdRestart = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    RespOk      = 2'd0,
    RespTimeout = 2'd1,
    RespIllegal = 2'd2
  } resp_e;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StStarting = 3'd1,
    StRunning  = 3'd2,
    StDrain    = 3'd3,
    StOffHold  = 3'd4
  } seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rocket_core_seq.sv
// Core enable sequencer: start settle, halt-request drain with timeout, and minimum off time
// before a command completes. All outputs are registered from the next state.

module rocket_core_seq
  import rocket_pkg::*;
#(
  parameter int unsigned START_CYCLES = 16,
  parameter int unsigned STOP_TIMEOUT = 1024,
  parameter int unsigned MIN_OFF      = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  output logic       resp_valid_o,
  output logic [1:0] resp_code_o,
  output logic       core_en_o,
  output logic       halt_req_o,
  input  logic       core_idle_i,
  output logic       running_o,
  output logic       busy_o
);

  localparam int unsigned CntMax = max3(START_CYCLES, STOP_TIMEOUT, MIN_OFF);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t StartLoad = cnt_t'(START_CYCLES);
  localparam cnt_t StopLoad  = cnt_t'(STOP_TIMEOUT);
  localparam cnt_t OffLoad   = cnt_t'(MIN_OFF);
  localparam cnt_t CntOne    = cnt_t'(1);

  seq_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       restart_pending_q, restart_pending_d;
  logic       timed_out_q, timed_out_d;
  logic       resp_valid_d;
  logic [1:0] resp_code_d;
  logic       accept;
  logic       cnt_last;

  // cmd_ready_o is registered from the state, so it is exactly "state is OFF or RUNNING".
  assign accept   = cmd_valid_i & cmd_ready_o;
  // A timed state loaded with N at entry lasts N cycles.
  assign cnt_last = (cnt_q <= CntOne);

  always_comb begin
    state_d           = state_q;
    cnt_d             = (cnt_q != '0) ? cnt_q - CntOne : cnt_q;
    restart_pending_d = restart_pending_q;
    timed_out_d       = timed_out_q;
    resp_valid_d      = 1'b0;
    resp_code_d       = RespOk;

    unique case (state_q)
      StOff: begin
        if (accept) begin
          unique case (cmd_e'(cmd_i))
            CmdStart: begin
              state_d = StStarting;
              cnt_d   = StartLoad;
            end
            CmdStop, CmdRestart: begin
              resp_valid_d = 1'b1;
              resp_code_d  = RespIllegal;
            end
            default: ;
          endcase
        end
      end

      StStarting: begin
        if (cnt_last) begin
          state_d           = StRunning;
          resp_valid_d      = 1'b1;
          resp_code_d       = timed_out_q ? RespTimeout : RespOk;
          restart_pending_d = 1'b0;
          timed_out_d       = 1'b0;
        end
      end

      StRunning: begin
        if (accept) begin
          unique case (cmd_e'(cmd_i))
            CmdStart: begin
              resp_valid_d = 1'b1;
              resp_code_d  = RespIllegal;
            end
            CmdStop, CmdRestart: begin
              state_d           = StDrain;
              cnt_d             = StopLoad;
              restart_pending_d = (cmd_e'(cmd_i) == CmdRestart);
            end
            default: ;
          endcase
        end
      end

      StDrain: begin
        // Idle takes priority over expiry in the same cycle.
        if (core_idle_i) begin
          state_d = StOffHold;
          cnt_d   = OffLoad;
        end else if (cnt_last) begin
          state_d     = StOffHold;
          cnt_d       = OffLoad;
          timed_out_d = 1'b1;
        end
      end

      StOffHold: begin
        if (cnt_last) begin
          if (restart_pending_q) begin
            state_d = StStarting;
            cnt_d   = StartLoad;
          end else begin
            state_d           = StOff;
            resp_valid_d      = 1'b1;
            resp_code_d       = timed_out_q ? RespTimeout : RespOk;
            restart_pending_d = 1'b0;
            timed_out_d       = 1'b0;
          end
        end
      end

      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= StOff;
      cnt_q             <= '0;
      restart_pending_q <= 1'b0;
      timed_out_q       <= 1'b0;
      resp_valid_o      <= 1'b0;
      resp_code_o       <= RespOk;
      core_en_o         <= 1'b0;
      halt_req_o        <= 1'b0;
      running_o         <= 1'b0;
      busy_o            <= 1'b0;
      cmd_ready_o       <= 1'b1;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      restart_pending_q <= restart_pending_d;
      timed_out_q       <= timed_out_d;
      resp_valid_o      <= resp_valid_d;
      resp_code_o       <= resp_code_d;
      core_en_o         <= (state_d == StStarting) || (state_d == StRunning) ||
                           (state_d == StDrain);
      halt_req_o        <= (state_d == StDrain);
      running_o         <= (state_d == StRunning);
      busy_o            <= (state_d == StStarting) || (state_d == StDrain) ||
                           (state_d == StOffHold);
      cmd_ready_o       <= (state_d == StOff) || (state_d == StRunning);
    end
  end

endmodule

// File: tb/tb_rocket_core_seq.sv
// Directed bench for rocket_core_seq: expected responses go into a scoreboard queue that a
// negedge monitor drains; level outputs are checked inline at hand-computed cycles.

module tb_rocket_core_seq;
  import rocket_pkg::*;

  localparam int CLK_HALF = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'd0;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic       core_en;
  logic       halt_req;
  logic       core_idle = 1'b0;
  logic       running;
  logic       busy;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   a;

  rocket_core_seq #(
    .START_CYCLES(16),
    .STOP_TIMEOUT(1024),
    .MIN_OFF     (8)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_i       (cmd),
    .resp_valid_o(resp_valid),
    .resp_code_o (resp_code),
    .core_en_o   (core_en),
    .halt_req_o  (halt_req),
    .core_idle_i (core_idle),
    .running_o   (running),
    .busy_o      (busy)
  );

  always #CLK_HALF clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns with cyc equal to the acceptance edge.
  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick(1);
    cmd_valid = 1'b0;
    cmd       = 2'd0;
  endtask

  task automatic expect_resp(input logic [1:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_core_en"}, 32'(core_en), 32'd0);
    check({tag, "_halt_req"}, 32'(halt_req), 32'd0);
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got code %0d at cycle %0d, expected no response",
                 resp_code, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_code", 32'(resp_code), 32'(mon_e.code));
        check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #(CLK_HALF * 2 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 cycles, expected completion");
    $fatal(1);
  end

  initial begin
    tick(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(1);

    // START: core_en right after acceptance, RUNNING + OK 16 cycles later.
    issue(CmdStart);
    a = cyc;
    expect_resp(RespOk, a + 16);
    check("start_core_en", 32'(core_en), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cmd_ready", 32'(cmd_ready), 32'd0);
    tick(15);
    check("start_not_yet_running", 32'(running), 32'd0);
    tick(1);
    check("start_running", 32'(running), 32'd1);
    check("start_busy_clear", 32'(busy), 32'd0);
    check("start_cmd_ready_back", 32'(cmd_ready), 32'd1);

    // START while RUNNING is illegal.
    issue(CmdStart);
    expect_resp(RespIllegal, cyc);
    tick(1);
    check("ill_start_running", 32'(running), 32'd1);
    check("ill_start_core_en", 32'(core_en), 32'd1);

    // STOP, idle 5 cycles later.
    issue(CmdStop);
    a = cyc;
    expect_resp(RespOk, a + 14);
    check("stop_halt", 32'(halt_req), 32'd1);
    check("stop_running_clear", 32'(running), 32'd0);
    tick(5);
    check("stop_core_en_still", 32'(core_en), 32'd1);
    core_idle = 1'b1;
    tick(1);
    core_idle = 1'b0;
    check("stop_core_en_off", 32'(core_en), 32'd0);
    check("stop_halt_off", 32'(halt_req), 32'd0);
    check("stop_busy_hold", 32'(busy), 32'd1);
    tick(7);
    check("stop_hold_ready", 32'(cmd_ready), 32'd0);
    tick(1);
    check("stop_off_ready", 32'(cmd_ready), 32'd1);
    check("stop_off_busy", 32'(busy), 32'd0);

    // STOP / RESTART while OFF are illegal; NOP gives nothing.
    issue(CmdStop);
    expect_resp(RespIllegal, cyc);
    check("ill_stop_core_en", 32'(core_en), 32'd0);
    tick(1);
    issue(CmdRestart);
    expect_resp(RespIllegal, cyc);
    check("ill_restart_busy", 32'(busy), 32'd0);
    tick(1);
    issue(CmdNop);
    tick(2);
    check("nop_ready", 32'(cmd_ready), 32'd1);

    // RESTART with idle after 3 cycles.
    issue(CmdStart);
    expect_resp(RespOk, cyc + 16);
    tick(16);
    issue(CmdRestart);
    a = cyc;
    expect_resp(RespOk, a + 28);
    tick(3);
    core_idle = 1'b1;
    tick(1);
    core_idle = 1'b0;
    check("restart_core_en_off", 32'(core_en), 32'd0);
    tick(7);
    check("restart_core_en_still_off", 32'(core_en), 32'd0);
    tick(1);
    check("restart_core_en_on", 32'(core_en), 32'd1);
    check("restart_starting_busy", 32'(busy), 32'd1);
    tick(16);
    check("restart_running", 32'(running), 32'd1);

    // STOP with idle stuck low: forced off after the full timeout.
    issue(CmdStop);
    a = cyc;
    expect_resp(RespTimeout, a + 1032);
    tick(1023);
    check("timeout_core_en_still", 32'(core_en), 32'd1);
    tick(1);
    check("timeout_core_en_off", 32'(core_en), 32'd0);
    tick(8);
    check("timeout_off_ready", 32'(cmd_ready), 32'd1);

    // Idle and expiry in the same cycle: OK, and the earlier timeout is not carried over.
    issue(CmdStart);
    expect_resp(RespOk, cyc + 16);
    tick(16);
    issue(CmdStop);
    a = cyc;
    expect_resp(RespOk, a + 1032);
    tick(1023);
    core_idle = 1'b1;
    tick(1);
    core_idle = 1'b0;
    check("tie_core_en_off", 32'(core_en), 32'd0);
    tick(8);

    // Reset during DRAIN.
    issue(CmdStart);
    expect_resp(RespOk, cyc + 16);
    tick(16);
    issue(CmdStop);
    tick(3);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("rst_drain");
    reset = 1'b0;
    tick(5);

    // Reset during STARTING.
    issue(CmdStart);
    tick(5);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("rst_start");
    reset = 1'b0;
    tick(20);
    check("rst_start_stays_off", 32'(core_en), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rocket_core_seq.md
# rocket_core_seq

Core enable sequencer for the Rocket tile. Accepts start/stop/restart commands from the tile control unit and produces the `core_en` level that the core clock-gate/reset controller consumes. Before removing `core_en`, it drains the core through a halt request with timeout. It also enforces a minimum off time and a start settle time, so a command only completes once the core is actually up or fully down.

## Interface
Parameters:
- `START_CYCLES`, 16: cycles `core_en_o` is held high before the core counts as running; covers enable sync plus reset-release delay downstream. Must be ≥1.
- `STOP_TIMEOUT`, 1024: maximum cycles in drain waiting for `core_idle_i`. Must be ≥1.
- `MIN_OFF`, 8: cycles `core_en_o` stays low before OFF/restart. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  tile clock
- `reset_i`  in  1  synchronous active-high reset
- `cmd_valid_i`  in  1  command valid
- `cmd_ready_o`  out  1  command accepted when valid & ready
- `cmd_i`  in  2  command: 0 NOP, 1 START, 2 STOP, 3 RESTART
- `resp_valid_o`  out  1  one-cycle completion pulse
- `resp_code_o`  out  2  0 OK, 1 TIMEOUT, 2 ILLEGAL; valid with `resp_valid_o`
- `core_en_o`  out  1  enable level to the core clock/reset controller
- `halt_req_o`  out  1  request for the core to stop issuing memory traffic
- `core_idle_i`  in  1  core has no outstanding transactions (synchronous to `clk_i`)
- `running_o`  out  1  high in RUNNING only
- `busy_o`  out  1  high in STARTING, DRAIN, OFF_HOLD

## Operation
- States: OFF, STARTING, RUNNING, DRAIN, OFF_HOLD. A single down-counter is shared by all timed states. A `restart_pending` flag and a `timed_out` flag are held alongside it.
- `cmd_ready_o` = 1 in OFF and RUNNING only.
- OFF + START: go to STARTING with `core_en_o`=1. After START_CYCLES cycles, go to RUNNING and issue resp OK.
- RUNNING + STOP or RESTART: go to DRAIN with `halt_req_o`=1. Set `restart_pending` for RESTART.
- DRAIN:
  - If `core_idle_i`=1 is sampled, go to OFF_HOLD.
  - If the counter expires with no idle seen, set `timed_out` and go to OFF_HOLD (forced stop).
  - Idle and expiry in the same cycle: idle wins, `timed_out` stays clear.
- OFF_HOLD:
  - `core_en_o`=0, `halt_req_o`=0 for MIN_OFF cycles.
  - Then go to STARTING if `restart_pending` is set, else go to OFF.
  - On entering OFF, issue resp OK, or TIMEOUT if `timed_out` is set.
- RESTART completion: resp is issued on entry to RUNNING. Code is TIMEOUT if the drain timed out, else OK. Flags clear on that response.
- Illegal commands complete next cycle with resp ILLEGAL and no state change: START in RUNNING; STOP/RESTART in OFF. NOP is accepted with no response.
- Counter width is $clog2(max(START_CYCLES, STOP_TIMEOUT, MIN_OFF)+1). The counter is loaded on state entry and never wraps.
- Reset: state OFF; flags and counter cleared; all outputs 0 except `cmd_ready_o`=1.
- Reset mid-operation: `core_en_o` and `halt_req_o` drop at the reset edge, and no response is issued for the aborted command.

## Timing
- All outputs are registered.
- START accepted at edge T: `core_en_o`=1 from T+1; RUNNING, `running_o`=1, and resp pulse at T+1+START_CYCLES.
- STOP accepted at T: `halt_req_o`=1 from T+1; counter starts at STOP_TIMEOUT.
- `core_idle_i` high sampled at edge D (in DRAIN): `core_en_o`=0 and `halt_req_o`=0 from D+1; OFF and resp at D+1+MIN_OFF.
- Timeout: with `core_idle_i` never high, `core_en_o` drops at T+1+STOP_TIMEOUT.
- Illegal resp is issued one cycle after acceptance.
- `resp_valid_o` is exactly one cycle wide. At most one response is outstanding, because `cmd_ready_o` is low while busy.

## Structure
- Shared package `rocket_pkg`: command encodings, response encodings, and the state enum for `rocket_core_seq`.
- Single module, no sub-module. The sequencer's `core_en_o` connects directly to the enable input of the core clock/reset controller.

## Test plan
- Reset, START (START_CYCLES=16) at T -> `core_en_o` rises T+1; `running_o` and resp OK at T+17.
- RUNNING, STOP, `core_idle_i` asserted 5 cycles later -> `core_en_o` low 6 cycles after drain entry; resp OK after 8 more cycles (MIN_OFF=8); `cmd_ready_o` returns high.
- STOP with `core_idle_i` stuck low (STOP_TIMEOUT=1024) -> forced off at T+1025; resp TIMEOUT at OFF entry.
- RESTART with idle after 3 cycles -> `core_en_o` low ≥8 cycles, then high; single resp OK on RUNNING entry.
- Illegal commands: START while RUNNING, STOP while OFF -> resp ILLEGAL next cycle; state unchanged.
- Reset pulse during DRAIN and again during STARTING -> outputs return to reset values at the reset edge; no resp pulse; idle/timeout in same cycle -> OK.
